ic_count_restore_ctrl: RTL and testbench
========================================

// Module: ic_count_restore_ctrl
// PURPOSE
//  - Sequential owner of the count value. Sits around the combinational inc/dec (±1/±2) unit:
//    drives its count input and controls, and captures its result and carry/borrow-out.
//  - Accepts one command per handshake: INC1/INC2/DEC1/DEC2/LOAD/RESTORE/CLEAR_HIST.
//  - Keeps a DEPTH-entry history stack; RESTORE undoes the last value-changing command.
// PARAMETERS
//  - N      7  MSB index; datapath is N+1 bits (same N as the inc/dec unit)
//  - DEPTH  4  history entries (>=2, power of two)
// PORTS
//  - clk          in   1      single clock, rising edge
//  - rst_n        in   1      synchronous reset, active-low
//  - cmd_valid    in   1      command present
//  - cmd_ready    out  1      block can accept a command
//  - cmd_op       in   3      0 NOP,1 INC1,2 INC2,3 DEC1,4 DEC2,5 LOAD,6 RESTORE,7 CLEAR_HIST
//  - cmd_data     in   N+1    LOAD value (ignored for other ops)
//  - count_o      out  N+1    current registered count
//  - ic_count     out  N+1    to inc/dec unit count input (= count_o)
//  - ic_dec_inc   out  1      to unit direction (0 inc, 1 dec)
//  - ic_one_two   out  1      to unit step (0 ±1, 1 ±2)
//  - ic_enable    out  1      to unit enable
//  - ic_result    in   N+1    from unit result vector
//  - ic_carry     in   1      from unit carry/borrow chain bit N
//  - rsp_valid    out  1      one-cycle pulse: command completed
//  - rsp_wrap     out  1      qualified by rsp_valid: arithmetic wrapped
//  - rsp_err      out  1      qualified by rsp_valid: RESTORE on empty history
//  - hist_level   out  log2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): count_o=0, history emptied, hist_level=0, state IDLE,
//    rsp_*=0, ic_enable=0. cmd_ready forced 0 while rst_n=0. Reset mid-EXEC abandons the command.
//  - FSM: IDLE --(cmd_valid&cmd_ready)--> EXEC --> IDLE. cmd_ready = (state==IDLE) & rst_n.
//    Throughput: one command per 2 cycles. Latency: accept edge +1 clk -> count_o/rsp_valid update.
//  - Accept edge: op and cmd_data registered; cmd_op ignored when not accepted.
//  - EXEC, arithmetic op: ic_enable=1, ic_dec_inc=(op is DEC*), ic_one_two=(op is *2);
//    at EXEC end: push old count, count_o<=ic_result, rsp_wrap<=ic_carry.
//  - Outside EXEC-arithmetic: ic_enable=0, ic_dec_inc=0, ic_one_two=0 (unit acts as buffer).
//  - Arithmetic is modulo 2^(N+1): 0xFF+1=0x00 wrap=1; 0x01-2=0xFF wrap=1; 0xFE+1 wrap=0.
//  - LOAD: push old count, count_o<=cmd_data, rsp_wrap=0.
//  - RESTORE: history non-empty -> pop, count_o<=popped, err=0; empty -> count unchanged, err=1.
//  - CLEAR_HIST: history emptied, count unchanged. NOP: nothing changes except rsp_valid pulse.
//  - Push when full: oldest entry overwritten (circular), hist_level stays DEPTH.
//  - Pushes happen even if new value equals old value.
//  - rsp_valid pulses exactly once per accepted command, in the cycle after EXEC.
//  - rsp_wrap/rsp_err are 0 whenever rsp_valid=0.
// STRUCTURE
//  - Shared package ic_pkg: op codes (OP_NOP..OP_CLEAR_HIST), FSM state encodings (ST_IDLE, ST_EXEC).
//  - Sub-module ic_history_stack: DEPTH x (N+1) LIFO.
//    Ports: push, pop, clear, din, dout, level. Overwrite-oldest on full push.
//  - Top holds FSM, count register and response registers. Inc/dec unit is instantiated
//    by the parent, not inside this block.
// TESTING
//  - Reset, then INC1 x3 from 0 -> count_o 1,2,3; each rsp_valid 2 clk apart; hist_level 3.
//  - LOAD 0xFF, INC2 -> count_o 0x01, rsp_wrap=1; DEC2 -> 0xFF, rsp_wrap=1.
//  - LOAD 0x10, INC1, DEC2, RESTORE, RESTORE -> count_o 0x10,0x11,0x0F,0x11,0x10.
//  - After CLEAR_HIST, RESTORE -> rsp_err=1, count unchanged, hist_level 0.
//  - DEPTH+2 LOADs (1..6, DEPTH=4), then 5 RESTOREs -> counts 5,4,3,2, then err=1 with count 2.
//  - cmd_valid held high throughout -> accepts only in IDLE; rst_n=0 during EXEC -> count_o=0,
//    no rsp_valid.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared definitions for the count/restore controller: command op codes,
// FSM state encodings and small op-decode helpers used by the top level.
package ic_pkg;

    // Command op codes as carried on cmd_op
    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_INC1       = 3'd1,
        OP_INC2       = 3'd2,
        OP_DEC1       = 3'd3,
        OP_DEC2       = 3'd4,
        OP_LOAD       = 3'd5,
        OP_RESTORE    = 3'd6,
        OP_CLEAR_HIST = 3'd7
    } ic_op_e;

    // Controller FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } ic_state_e;

    // True for ops that go through the external inc/dec unit
    function automatic logic op_is_arith(input ic_op_e op);
        return (op == OP_INC1) || (op == OP_INC2) ||
               (op == OP_DEC1) || (op == OP_DEC2);
    endfunction

    // True for the decrementing ops (drives the unit direction)
    function automatic logic op_is_dec(input ic_op_e op);
        return (op == OP_DEC1) || (op == OP_DEC2);
    endfunction

    // True for the two-step ops (drives the unit step size)
    function automatic logic op_is_two(input ic_op_e op);
        return (op == OP_INC2) || (op == OP_DEC2);
    endfunction

    // True for ops that change the value and therefore save the old one
    function automatic logic op_pushes(input ic_op_e op);
        return op_is_arith(op) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/ic_history_stack.sv
// DEPTH x W LIFO holding previous count values. Implemented as a circular
// buffer: a push onto a full stack lands on the oldest slot, so the oldest
// value is silently dropped and the level saturates at DEPTH.
module ic_history_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] top_idx_s;
    logic [LW-1:0] level_q;
    logic          full_s;
    logic          empty_s;

    assign top_idx_s = wp_q - {{(AW-1){1'b0}}, 1'b1};
    assign full_s    = (level_q == LW'(DEPTH));
    assign empty_s   = (level_q == {LW{1'b0}});
    assign dout      = mem_q[top_idx_s];
    assign level     = level_q;

    // Pointer and occupancy: clear wins, then push, then pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= {AW{1'b0}};
            level_q <= {LW{1'b0}};
        end else if (clear) begin
            wp_q    <= {AW{1'b0}};
            level_q <= {LW{1'b0}};
        end else if (push) begin
            wp_q <= wp_q + {{(AW-1){1'b0}}, 1'b1};
            if (!full_s) begin
                level_q <= level_q + {{(LW-1){1'b0}}, 1'b1};
            end else begin
                level_q <= level_q;
            end
        end else if (pop && !empty_s) begin
            wp_q    <= top_idx_s;
            level_q <= level_q - {{(LW-1){1'b0}}, 1'b1};
        end else begin
            wp_q    <= wp_q;
            level_q <= level_q;
        end
    end

    // Storage write; contents need no reset since level gates their use
    always_ff @(posedge clk) begin
        if (rst_n && !clear && push) begin
            mem_q[wp_q] <= din;
        end
    end

endmodule

// File: rtl/ic_count_restore_ctrl.sv
// Sequential owner of the count value. Drives the external combinational
// inc/dec unit, captures its result, and keeps a history stack so RESTORE
// can undo the most recent value-changing command. One command is accepted
// in IDLE, executed in EXEC, and answered with a one-cycle rsp_valid.
module ic_count_restore_ctrl
    import ic_pkg::*;
#(
    parameter int N     = 7,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [N:0]             cmd_data,
    output logic [N:0]             count_o,
    output logic [N:0]             ic_count,
    output logic                   ic_dec_inc,
    output logic                   ic_one_two,
    output logic                   ic_enable,
    input  logic [N:0]             ic_result,
    input  logic                   ic_carry,
    output logic                   rsp_valid,
    output logic                   rsp_wrap,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] hist_level
);

    localparam int LW = $clog2(DEPTH) + 1;

    ic_state_e     state_q;
    ic_op_e        op_q;
    logic [N:0]    data_q;
    logic [N:0]    count_q;
    logic [N:0]    count_d;
    logic          rsp_valid_q;
    logic          rsp_wrap_q;
    logic          rsp_wrap_d;
    logic          rsp_err_q;
    logic          rsp_err_d;

    logic          exec_s;
    logic          arith_s;
    logic          accept_s;
    logic          hist_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          clear_s;
    logic [N:0]    hist_dout_s;
    logic [LW-1:0] hist_level_s;

    assign exec_s       = (state_q == ST_EXEC);
    assign arith_s      = exec_s && op_is_arith(op_q);
    assign cmd_ready    = (state_q == ST_IDLE) && rst_n;
    assign accept_s     = cmd_valid && cmd_ready;
    assign hist_empty_s = (hist_level_s == {LW{1'b0}});

    // History control is only ever active in EXEC, and at most one at a time
    assign push_s  = exec_s && op_pushes(op_q);
    assign pop_s   = exec_s && (op_q == OP_RESTORE) && !hist_empty_s;
    assign clear_s = exec_s && (op_q == OP_CLEAR_HIST);

    // Outside an arithmetic EXEC the unit is a plain buffer of the count
    assign ic_enable  = arith_s;
    assign ic_dec_inc = arith_s && op_is_dec(op_q);
    assign ic_one_two = arith_s && op_is_two(op_q);
    assign ic_count   = count_q;

    assign count_o    = count_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_wrap   = rsp_wrap_q;
    assign rsp_err    = rsp_err_q;
    assign hist_level = hist_level_s;

    ic_history_stack #(
        .W     (N + 1),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .clear (clear_s),
        .din   (count_q),
        .dout  (hist_dout_s),
        .level (hist_level_s)
    );

    // Result of the registered op, consumed only at the end of EXEC
    always_comb begin
        count_d    = count_q;
        rsp_wrap_d = 1'b0;
        rsp_err_d  = 1'b0;
        case (op_q)
            OP_INC1, OP_INC2, OP_DEC1, OP_DEC2: begin
                count_d    = ic_result;
                rsp_wrap_d = ic_carry;
            end
            OP_LOAD: begin
                count_d = data_q;
            end
            OP_RESTORE: begin
                if (!hist_empty_s) begin
                    count_d = hist_dout_s;
                end else begin
                    rsp_err_d = 1'b1;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Controller FSM with count and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            data_q      <= {(N+1){1'b0}};
            count_q     <= {(N+1){1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_wrap_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_wrap_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q <= ST_EXEC;
                        op_q    <= ic_op_e'(cmd_op);
                        data_q  <= cmd_data;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    state_q     <= ST_IDLE;
                    count_q     <= count_d;
                    rsp_valid_q <= 1'b1;
                    rsp_wrap_q  <= rsp_wrap_d;
                    rsp_err_q   <= rsp_err_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ic_count_restore_ctrl.sv
// Self-checking bench for ic_count_restore_ctrl: directed scenarios with
// hand-computed values, then randomized traffic, all checked every cycle
// against a behavioural model (integer count plus a queue as the history).
module tb_ic_count_restore_ctrl;

    localparam int N     = 7;
    localparam int DEPTH = 4;
    localparam int W     = N + 1;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int MOD   = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [N:0]    cmd_data;
    logic [N:0]    count_o;
    logic [N:0]    ic_count;
    logic          ic_dec_inc;
    logic          ic_one_two;
    logic          ic_enable;
    logic [N:0]    ic_result;
    logic          ic_carry;
    logic          rsp_valid;
    logic          rsp_wrap;
    logic          rsp_err;
    logic [LW-1:0] hist_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ic_count_restore_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .count_o    (count_o),
        .ic_count   (ic_count),
        .ic_dec_inc (ic_dec_inc),
        .ic_one_two (ic_one_two),
        .ic_enable  (ic_enable),
        .ic_result  (ic_result),
        .ic_carry   (ic_carry),
        .rsp_valid  (rsp_valid),
        .rsp_wrap   (rsp_wrap),
        .rsp_err    (rsp_err),
        .hist_level (hist_level)
    );

    // Stand-in for the external combinational inc/dec unit
    logic [W:0] ic_sum_s;
    logic [W:0] ic_diff_s;
    assign ic_sum_s  = {1'b0, ic_count} + (ic_one_two ? 9'd2 : 9'd1);
    assign ic_diff_s = {1'b0, ic_count} - (ic_one_two ? 9'd2 : 9'd1);
    assign ic_result = ic_enable ? (ic_dec_inc ? ic_diff_s[N:0] : ic_sum_s[N:0]) : ic_count;
    assign ic_carry  = ic_enable && (ic_dec_inc ? ic_diff_s[W] : ic_sum_s[W]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_cnt   = 0;
    int  hist[$];
    bit  m_pend  = 1'b0;
    int  m_op    = 0;
    int  m_data  = 0;
    bit  m_rv    = 1'b0;
    bit  m_rw    = 1'b0;
    bit  m_re    = 1'b0;
    bit  m_valid = 1'b0;
    int  cyc     = 0;

    function automatic void m_push(input int v);
        hist.push_back(v);
        if (hist.size() > DEPTH) void'(hist.pop_front());
    endfunction

    // Model advances one clock: finish a pending command or take a new one
    always @(posedge clk) begin
        int step;
        cyc++;
        if (!rst_n) begin
            m_cnt = 0; hist.delete(); m_pend = 1'b0;
            m_rv = 1'b0; m_rw = 1'b0; m_re = 1'b0; m_valid = 1'b1;
        end else begin
            m_rv = 1'b0; m_rw = 1'b0; m_re = 1'b0;
            if (m_pend) begin
                m_pend = 1'b0;
                m_rv   = 1'b1;
                step   = (m_op == 2 || m_op == 4) ? 2 : 1;
                case (m_op)
                    1, 2: begin
                        m_rw = (m_cnt + step) >= MOD;
                        m_push(m_cnt);
                        m_cnt = (m_cnt + step) % MOD;
                    end
                    3, 4: begin
                        m_rw = m_cnt < step;
                        m_push(m_cnt);
                        m_cnt = (m_cnt - step + MOD) % MOD;
                    end
                    5: begin
                        m_push(m_cnt);
                        m_cnt = m_data;
                    end
                    6: begin
                        if (hist.size() > 0) m_cnt = hist.pop_back();
                        else m_re = 1'b1;
                    end
                    7: hist.delete();
                    default: ;
                endcase
            end else if (cmd_valid) begin
                m_pend = 1'b1;
                m_op   = int'(cmd_op);
                m_data = int'(cmd_data);
            end
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("count_o",    32'(count_o),    32'(m_cnt));
            chk("ic_count",   32'(ic_count),   32'(m_cnt));
            chk("rsp_valid",  32'(rsp_valid),  32'(m_rv));
            chk("rsp_wrap",   32'(rsp_wrap),   32'(m_rw));
            chk("rsp_err",    32'(rsp_err),    32'(m_re));
            chk("hist_level", 32'(hist_level), 32'(hist.size()));
            chk("cmd_ready",  32'(cmd_ready),  32'(!m_pend && rst_n));
            chk("ic_enable",  32'(ic_enable),  32'(m_pend && m_op >= 1 && m_op <= 4));
            chk("ic_dec_inc", 32'(ic_dec_inc), 32'(m_pend && (m_op == 3 || m_op == 4)));
            chk("ic_one_two", 32'(ic_one_two), 32'(m_pend && (m_op == 2 || m_op == 4)));
        end
    end

    // ---------------- directed helpers ----------------
    // Called at posedge+2; returns at posedge+2 of the response cycle
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d,
                           output logic [7:0] c, output logic w, output logic e,
                           output int rc);
        int t;
        t = 0;
        while (!cmd_ready && t < 20) begin @(posedge clk); #2; t++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #2;
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
        t = 0;
        while (!rsp_valid && t < 20) begin @(posedge clk); #2; t++; end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: got rsp_valid=%0b, expected 1 for op %0d", rsp_valid, op);
        end
        c = count_o; w = rsp_wrap; e = rsp_err; rc = cyc;
    endtask

    logic [7:0] c;
    logic       w, e;
    int         r1, r2, r3, pulses;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst count_o",    32'(count_o),    32'h0);
        chk("rst hist_level", 32'(hist_level), 32'h0);
        chk("rst rsp_valid",  32'(rsp_valid),  32'h0);
        chk("rst cmd_ready",  32'(cmd_ready),  32'h0);
        chk("rst ic_enable",  32'(ic_enable),  32'h0);
        rst_n = 1'b1;
        #1;
        chk("ready after rst", 32'(cmd_ready), 32'h1);

        // INC1 x3 from zero, responses two clocks apart
        run_cmd(3'd1, 8'h00, c, w, e, r1); chk("inc1 #1", 32'(c), 32'h01);
        run_cmd(3'd1, 8'h00, c, w, e, r2); chk("inc1 #2", 32'(c), 32'h02);
        run_cmd(3'd1, 8'h00, c, w, e, r3); chk("inc1 #3", 32'(c), 32'h03);
        chk("rsp spacing 1-2", 32'(r2 - r1), 32'd2);
        chk("rsp spacing 2-3", 32'(r3 - r2), 32'd2);
        chk("hist after inc", 32'(hist_level), 32'd3);

        // Wrap cases
        run_cmd(3'd5, 8'hFF, c, w, e, r1); chk("load ff", 32'(c), 32'hFF);
        run_cmd(3'd2, 8'h00, c, w, e, r1); chk("inc2 wrap val", 32'(c), 32'h01);
        chk("inc2 wrap flag", 32'(w), 32'h1);
        run_cmd(3'd4, 8'h00, c, w, e, r1); chk("dec2 wrap val", 32'(c), 32'hFF);
        chk("dec2 wrap flag", 32'(w), 32'h1);
        run_cmd(3'd5, 8'hFE, c, w, e, r1);
        run_cmd(3'd1, 8'h00, c, w, e, r1); chk("inc1 fe val", 32'(c), 32'hFF);
        chk("inc1 fe no wrap", 32'(w), 32'h0);

        // Undo chain
        run_cmd(3'd5, 8'h10, c, w, e, r1); chk("load 10", 32'(c), 32'h10);
        run_cmd(3'd1, 8'h00, c, w, e, r1); chk("undo inc1", 32'(c), 32'h11);
        run_cmd(3'd4, 8'h00, c, w, e, r1); chk("undo dec2", 32'(c), 32'h0F);
        run_cmd(3'd6, 8'h00, c, w, e, r1); chk("restore 1", 32'(c), 32'h11);
        run_cmd(3'd6, 8'h00, c, w, e, r1); chk("restore 2", 32'(c), 32'h10);

        // Restore on cleared history
        run_cmd(3'd7, 8'h00, c, w, e, r1); chk("clear hist lvl", 32'(hist_level), 32'd0);
        run_cmd(3'd6, 8'h00, c, w, e, r1);
        chk("empty restore err", 32'(e), 32'h1);
        chk("empty restore cnt", 32'(c), 32'h10);
        chk("empty restore lvl", 32'(hist_level), 32'd0);

        // Overflowing the history keeps the newest DEPTH entries
        for (int i = 1; i <= DEPTH + 2; i++) run_cmd(3'd5, 8'(i), c, w, e, r1);
        chk("hist saturates", 32'(hist_level), 32'(DEPTH));
        for (int i = 0; i < 4; i++) begin
            run_cmd(3'd6, 8'h00, c, w, e, r1);
            chk("ovf restore", 32'(c), 32'(5 - i));
            chk("ovf restore err", 32'(e), 32'h0);
        end
        run_cmd(3'd6, 8'h00, c, w, e, r1);
        chk("ovf final err", 32'(e), 32'h1);
        chk("ovf final cnt", 32'(c), 32'h02);

        // cmd_valid held high: one command every two clocks
        cmd_valid = 1'b1; cmd_op = 3'd1; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            if (rsp_valid) pulses++;
        end
        cmd_valid = 1'b0;
        chk("held valid pulses", 32'(pulses), 32'd4);
        chk("held valid count", 32'(count_o), 32'h06);

        // Reset during EXEC abandons the command
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 8'h55;
        @(posedge clk); #2;
        cmd_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #2;
        chk("mid-exec rst count", 32'(count_o), 32'h0);
        chk("mid-exec rst rsp", 32'(rsp_valid), 32'h0);
        chk("mid-exec rst lvl", 32'(hist_level), 32'h0);
        rst_n = 1'b1;

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            rst_n     = ($urandom_range(0, 99) != 0);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
